// File: rtl/usb_speed_detect_if.sv
// usb_speed_detect_if: PHY linestate, register-block controls and speed-detect status.
interface usb_speed_detect_if;
   logic       fe_linestate0;
   logic       fe_linestate1;
   logic       I_restart;
   logic       I_hs_enable;
   logic [1:0] O_speed;
   logic       O_done;
   logic       O_error;
   logic [3:0] O_chirp_count;
   modport master (
      output fe_linestate0, fe_linestate1, I_restart, I_hs_enable,
      input  O_speed, O_done, O_error, O_chirp_count
   );
   modport slave (
      input  fe_linestate0, fe_linestate1, I_restart, I_hs_enable,
      output O_speed, O_done, O_error, O_chirp_count
   );
endinterface

// File: rtl/usb_speed_detect.sv
// usb_speed_detect: LS/FS attach and HS chirp handshake detector on glitch-filtered PHY linestate.
module usb_speed_detect #(
   parameter int pCOUNTER_WIDTH    = 20,
   parameter int pGLITCH_CYCLES    = 4,
   parameter int pATTACH_CYCLES    = 60000,
   parameter int pRESET_TIMEOUT    = 600000,
   parameter int pCHIRP_MIN_CYCLES = 60000,
   parameter int pCHIRP_MAX_CYCLES = 420000,
   parameter int pSEG_MAX_CYCLES   = 4000,
   parameter int pCHIRP_PAIRS      = 3
) (
   input logic               fe_clk,
   input logic               reset_i,
   usb_speed_detect_if.slave bus
);
   localparam logic [1:0] SPD_AUTO = 2'd0, SPD_LS = 2'd1, SPD_FS = 2'd2, SPD_HS = 2'd3;
   localparam int GW = $clog2(pGLITCH_CYCLES + 1);
   localparam logic [GW-1:0] GLITCH_LAST = GW'(pGLITCH_CYCLES - 1);
   localparam logic [pCOUNTER_WIDTH-1:0] ATTACH_T = pCOUNTER_WIDTH'(pATTACH_CYCLES);
   localparam logic [pCOUNTER_WIDTH-1:0] RESET_T  = pCOUNTER_WIDTH'(pRESET_TIMEOUT);
   localparam logic [pCOUNTER_WIDTH-1:0] CMIN_T   = pCOUNTER_WIDTH'(pCHIRP_MIN_CYCLES);
   localparam logic [pCOUNTER_WIDTH-1:0] CMAX_T   = pCOUNTER_WIDTH'(pCHIRP_MAX_CYCLES);
   localparam logic [pCOUNTER_WIDTH-1:0] SEG_T    = pCOUNTER_WIDTH'(pSEG_MAX_CYCLES);
   localparam logic [3:0] CHIRP_DONE = 4'(2 * pCHIRP_PAIRS);

   typedef enum logic [3:0] {
      IDLE, LS_WAIT, FS_WAIT, FS_ATTACHED, RESET_SEEN, DEV_CHIRP, HOST_CHIRP, DONE, ERROR
   } state_t;

   state_t                    state, state_nx;
   logic [1:0]                sync1, sync2, cand, filt, filt_q;
   logic [GW-1:0]             glitch_cnt;
   logic [pCOUNTER_WIDTH-1:0] timer;
   logic [3:0]                chirp_cnt, chirp_nx;
   logic [1:0]                dec_spd, dec_nx;
   logic                      seg_step;

   // filt follows sync2 only after it has held one value for pGLITCH_CYCLES samples
   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         sync1      <= '0;
         sync2      <= '0;
         cand       <= '0;
         glitch_cnt <= '0;
         filt       <= '0;
         filt_q     <= '0;
      end else begin
         sync1  <= {bus.fe_linestate1, bus.fe_linestate0};
         sync2  <= sync1;
         filt_q <= filt;
         if (sync2 != cand) begin
            cand       <= sync2;
            glitch_cnt <= '0;
         end else if (glitch_cnt != GLITCH_LAST) begin
            glitch_cnt <= glitch_cnt + 1'b1;
         end
         if (sync2 == cand && glitch_cnt == GLITCH_LAST) filt <= cand;
      end
   end

   always_comb begin
      state_nx = state;
      chirp_nx = chirp_cnt;
      dec_nx   = dec_spd;
      seg_step = 1'b0;
      if (bus.I_restart) begin
         state_nx = IDLE;
         chirp_nx = '0;
      end else begin
         case (state)
            IDLE: state_nx = filt == 2'b10 ? LS_WAIT : filt == 2'b01 ? FS_WAIT : IDLE;
            LS_WAIT:
               if (filt != 2'b10) state_nx = ERROR;
               else if (timer >= ATTACH_T) begin
                  state_nx = DONE;
                  dec_nx   = SPD_LS;
               end
            FS_WAIT:
               if (filt != 2'b01) state_nx = ERROR;
               else if (timer >= ATTACH_T) begin
                  state_nx = bus.I_hs_enable ? FS_ATTACHED : DONE;
                  dec_nx   = SPD_FS;
               end
            FS_ATTACHED: state_nx = filt == 2'b00 ? RESET_SEEN : filt == 2'b11 ? ERROR : FS_ATTACHED;
            RESET_SEEN:
               if (filt == 2'b10) state_nx = DEV_CHIRP;
               else if (filt == 2'b11) state_nx = ERROR;
               else if (filt == 2'b01 || timer >= RESET_T) begin
                  state_nx = DONE;
                  dec_nx   = SPD_FS;
               end
            DEV_CHIRP:
               if (timer >= CMAX_T) state_nx = ERROR;
               else if (filt != 2'b10) begin
                  state_nx = (timer >= CMIN_T && !filt[1]) ? HOST_CHIRP : ERROR;
                  chirp_nx = '0;
               end
            // the SE0 gap after the device chirp is tolerated only until the first host segment
            HOST_CHIRP:
               if (chirp_cnt == CHIRP_DONE) begin
                  state_nx = DONE;
                  dec_nx   = SPD_HS;
               end else if (filt == 2'b11 || (filt == 2'b00 && chirp_cnt != 4'd0) || timer >= SEG_T) begin
                  state_nx = ERROR;
               end else if (filt != filt_q && filt != 2'b00) begin
                  seg_step = 1'b1;
                  chirp_nx = chirp_cnt + 1'b1;
               end
            default: state_nx = state;
         endcase
      end
   end

   always_ff @(posedge fe_clk or posedge reset_i) begin
      if (reset_i) begin
         state       <= IDLE;
         timer       <= '0;
         chirp_cnt   <= '0;
         dec_spd     <= SPD_AUTO;
         bus.O_speed <= SPD_AUTO;
         bus.O_done  <= 1'b0;
         bus.O_error <= 1'b0;
      end else begin
         state       <= state_nx;
         chirp_cnt   <= chirp_nx;
         dec_spd     <= dec_nx;
         timer       <= (state_nx != state || seg_step || bus.I_restart) ? '0 : &timer ? timer : timer + 1'b1;
         bus.O_speed <= state == DONE ? dec_spd :
                        (state inside {FS_ATTACHED, RESET_SEEN, DEV_CHIRP, HOST_CHIRP}) ? SPD_FS : SPD_AUTO;
         bus.O_done  <= state == DONE;
         bus.O_error <= state == ERROR;
      end
   end

   assign bus.O_chirp_count = chirp_cnt;
endmodule
